// File: rtl/jtppi_fifo.sv
// jtppi_fifo: parametrised parallel I/O ports with per-bit direction and strobed input FIFOs
module jtppi_fifo #(
   parameter int DW     = 8,
   parameter int NPORTS = 2,
   parameter int FDEPTH = 4,
   parameter int AW     = $clog2(NPORTS) + 2
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AW-1:0]        addr,
   input  logic [DW-1:0]        din,
   output logic [DW-1:0]        dout,
   input  logic                 rdn,
   input  logic                 wrn,
   input  logic                 csn,
   input  logic [NPORTS*DW-1:0] port_din,
   output logic [NPORTS*DW-1:0] port_dout,
   output logic [NPORTS*DW-1:0] port_oe,
   input  logic [NPORTS-1:0]    stb,
   output logic [NPORTS-1:0]    ibf,
   output logic                 intn
);
   localparam int FW = $clog2(FDEPTH);
   logic wr, rd, last_wr, last_rd, wcommit, rd_lead;
   logic [DW-1:0] din_r, rdata;
   logic [AW-1:0] addr_r, wport, rport;
   logic [NPORTS*DW-1:0] rd_all;
   logic [NPORTS-1:0] intr;
   assign wr      = !wrn && !csn;
   assign rd      = !rdn && !csn;
   assign wcommit = last_wr && !wr;
   assign rd_lead = rd && !last_rd;
   assign wport   = addr_r >> 2;
   assign rport   = addr >> 2;
   // address is captured with din so the commit cycle sees the bus as it was during the write
   always_ff @(posedge clk) begin
      din_r  <= din;
      addr_r <= addr;
      if (rst) begin
         last_wr <= 1'b0;
         last_rd <= 1'b0;
         dout    <= '1;
         intn    <= 1'b1;
      end else begin
         last_wr <= wr;
         last_rd <= rd;
         intn    <= ~|intr;
         if (rd_lead) dout <= rdata;
      end
   end
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NPORTS; i++)
         if (rport == AW'(i)) rdata = rd_all[i*DW +: DW];
   end
   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic [DW-1:0] lat, dir, pin, head, status;
      logic [DW-1:0] mem [FDEPTH];
      logic [FW-1:0] wp, rp;
      logic [FW:0] cnt;
      logic [3:0] cnt4;
      logic [1:0] ctrl;
      logic ovr, last_stb, empty, full, wsel, flush, ovr_clr, push_req, do_pop, do_push;
      assign pin      = port_din[p*DW +: DW];
      assign wsel     = wcommit && wport == AW'(p);
      assign flush    = wsel && addr_r[1:0] == 2'd2 && (din_r[2] || !din_r[0]);
      assign ovr_clr  = wsel && addr_r[1:0] == 2'd3 && din_r[2];
      assign empty    = cnt == '0;
      assign full     = cnt[FW];
      assign push_req = ctrl[0] && stb[p] && !last_stb;
      assign do_pop   = rd_lead && rport == AW'(p) && addr[1:0] == 2'd0 && ctrl[0] && !empty;
      // a pop on the same edge frees the slot, so a full FIFO still accepts the push
      assign do_push  = push_req && (!full || do_pop) && !flush;
      assign head     = empty ? '0 : mem[rp];
      assign cnt4     = 32'(cnt) > 15 ? 4'hf : 4'(cnt);
      assign status   = DW'({cnt4, intr[p], ovr, full, empty});
      assign intr[p]  = ctrl[1] && (!empty || ovr);
      assign ibf[p]   = !empty;
      assign port_dout[p*DW +: DW] = lat;
      assign port_oe[p*DW +: DW]   = ~dir;
      assign rd_all[p*DW +: DW] = addr[1:0] == 2'd0 ? (ctrl[0] ? head : (dir & pin) | (~dir & lat))
                                : addr[1:0] == 2'd1 ? dir
                                : addr[1:0] == 2'd2 ? DW'(ctrl) : status;
      always_ff @(posedge clk) if (do_push) mem[wp] <= pin;
      always_ff @(posedge clk) begin
         if (rst) begin
            lat      <= '0;
            dir      <= '1;
            ctrl     <= '0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            ovr      <= 1'b0;
            last_stb <= 1'b0;
         end else begin
            last_stb <= stb[p];
            if (wsel && addr_r[1:0] == 2'd0) lat  <= din_r;
            if (wsel && addr_r[1:0] == 2'd1) dir  <= din_r;
            if (wsel && addr_r[1:0] == 2'd2) ctrl <= din_r[1:0];
            if (flush) begin
               wp  <= '0;
               rp  <= '0;
               cnt <= '0;
               ovr <= 1'b0;
            end else begin
               wp  <= wp + FW'(do_push);
               rp  <= rp + FW'(do_pop);
               cnt <= cnt + (FW+1)'(do_push) - (FW+1)'(do_pop);
               ovr <= (push_req && full && !do_pop) || (ovr && !ovr_clr);
            end
         end
      end
   end
endmodule

// File: tb/tb_jtppi_fifo.sv
// tb_jtppi_fifo: scoreboard bench for the 2-port, 4-deep configuration
module tb_jtppi_fifo;
   logic clk = 0, rst = 1;
   logic [2:0] addr = 0;
   logic [7:0] din = 0, dout;
   logic rdn = 1, wrn = 1, csn = 1;
   logic [15:0] port_din = 16'hA53C, port_dout, port_oe;
   logic [1:0] stb = 0, ibf;
   logic intn;
   int n_vec = 0, n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mq[$];

   jtppi_fifo dut (
      .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
      .rdn(rdn), .wrn(wrn), .csn(csn), .port_din(port_din),
      .port_dout(port_dout), .port_oe(port_oe), .stb(stb), .ibf(ibf), .intn(intn)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk); addr = a; din = d; csn = 0; wrn = 0;
      @(negedge clk); wrn = 1; csn = 1;
      @(negedge clk);
   endtask

   task automatic rd_reg(input string tag, input logic [2:0] a, input logic [7:0] e);
      @(negedge clk); addr = a; csn = 0; rdn = 0; exp_q.push_back(e);
      @(negedge clk); rdn = 1; csn = 1;
      chk(tag, dout, exp_q.pop_front());
   endtask

   // only port 0 is modelled as a queue; port 1 is checked through its status
   task automatic push(input int p, input logic [7:0] v);
      @(negedge clk); port_din[p*8 +: 8] = v; stb[p] = 1;
      if (p == 0 && mq.size() < 4) mq.push_back(v);
      @(negedge clk); stb[p] = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      chk("rst_dout", dout, 8'hFF);
      chk("rst_intn", intn, 1);
      chk("rst_oe", port_oe, 16'h0000);
      chk("rst_pdout", port_dout, 16'h0000);
      chk("rst_ibf", ibf, 2'b00);
      rd_reg("rst_data0", 3'd0, 8'h3C);
      rd_reg("rst_dir", 3'd1, 8'hFF);
      rd_reg("rst_ctrl", 3'd2, 8'h00);
      rd_reg("rst_status", 3'd3, 8'h01);
      rd_reg("rst_data1", 3'd4, 8'hA5);
      chk("rst_intn2", intn, 1);

      port_din[7:0] = 8'hC3;
      wr_reg(3'd1, 8'h0F);
      wr_reg(3'd0, 8'h5A);
      chk("latch", port_dout[7:0], 8'h5A);
      chk("oe", port_oe[7:0], 8'hF0);
      rd_reg("mixed_read", 3'd0, 8'h53);
      rd_reg("dir_read", 3'd1, 8'h0F);

      wr_reg(3'd2, 8'h03);
      chk("intn_idle", intn, 1);
      @(negedge clk); port_din[7:0] = 8'h11; stb[0] = 1; mq.push_back(8'h11);
      @(negedge clk); stb[0] = 0;
      chk("intn_lag", intn, 1);
      chk("ibf0_set", ibf[0], 1);
      @(negedge clk);
      chk("intn_set", intn, 0);
      push(0, 8'h22);
      push(0, 8'h33);
      rd_reg("status_3", 3'd3, 8'h38);
      for (int i = 0; i < 3; i++) rd_reg("fifo_a", 3'd0, mq.pop_front());
      rd_reg("status_empty", 3'd3, 8'h01);
      chk("intn_clear", intn, 1);

      for (int i = 0; i < 5; i++) push(0, 8'hA1 + 8'(i));
      rd_reg("status_ovr", 3'd3, 8'h4E);
      chk("intn_ovr", intn, 0);
      wr_reg(3'd3, 8'h04);
      rd_reg("status_ovrclr", 3'd3, 8'h4A);
      @(negedge clk); addr = 0; csn = 0; rdn = 0; stb[0] = 1; port_din[7:0] = 8'hB6;
      exp_q.push_back(mq.pop_front()); mq.push_back(8'hB6);
      @(negedge clk); rdn = 1; csn = 1; stb[0] = 0;
      chk("pop_push", dout, exp_q.pop_front());
      rd_reg("status_pp", 3'd3, 8'h4A);
      for (int i = 0; i < 4; i++) rd_reg("fifo_b", 3'd0, mq.pop_front());
      rd_reg("status_drained", 3'd3, 8'h01);

      push(0, 8'h77);
      wr_reg(3'd6, 8'h03);
      push(1, 8'h44);
      push(1, 8'h55);
      rd_reg("p1_status", 3'd7, 8'h28);
      chk("ibf_both", ibf, 2'b11);
      @(negedge clk); addr = 3'd6; din = 8'h07; csn = 0; wrn = 0;
      @(negedge clk); wrn = 1; csn = 1; stb[1] = 1; port_din[15:8] = 8'h99;
      @(negedge clk); stb[1] = 0;
      chk("ibf_flush", ibf, 2'b01);
      rd_reg("p1_flushed", 3'd7, 8'h01);
      rd_reg("p1_ctrl", 3'd6, 8'h03);
      rd_reg("p1_empty_rd", 3'd4, 8'h00);
      rd_reg("p0_status", 3'd3, 8'h18);
      rd_reg("p0_data", 3'd0, mq.pop_front());
      @(negedge clk);
      chk("intn_final", intn, 1);

      push(0, 8'h88);
      wr_reg(3'd2, 8'h02);
      mq.delete();
      rd_reg("mode0_flush", 3'd3, 8'h01);
      chk("ibf_mode0", ibf, 2'b00);
      rd_reg("ctrl_mode0", 3'd2, 8'h02);
      rd_reg("mode0_data", 3'd0, 8'h58);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
